chrram_arbiter: RTL and testbench

//  Sole access controller for the 80x25 character/attribute RAM (2000 x 16b words, {code,attr}).

---
 rtl/chrram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_chrram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chrram_arbiter.sv
// chrram_arbiter: one-access-per-clock controller for the 80x25 character RAM (video > clear > host)
module chrram_arbiter #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_req,
    input  logic [6:0]  vid_col,
    input  logic [4:0]  vid_row,
    output logic        vid_valid,
    output logic [7:0]  vid_code,
    output logic [7:0]  vid_attr,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [10:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_done,
    output logic [15:0] host_rdata,
    input  logic        clr_start,
    input  logic [15:0] clr_data,
    output logic        clr_busy,
    output logic [10:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);
    localparam int CELLS = COLS * ROWS;
    localparam logic [10:0] LAST = 11'(CELLS - 1);

    typedef enum logic [1:0] {IDLE, HOST_WAIT, HOST_RD, CLEAR} state_t;

    state_t          state_q, state_d;
    logic            pend_we_q, pend_we_d;
    logic [10:0]     pend_addr_q, pend_addr_d;
    logic [15:0]     pend_wdata_q, pend_wdata_d;
    logic [10:0]     clr_addr_q, clr_addr_d;
    logic [15:0]     clr_data_q, clr_data_d;
    logic [10:0]     ram_addr_q, ram_addr_d;
    logic            ram_we_q, ram_we_d;
    logic [15:0]     ram_wdata_q, ram_wdata_d;
    logic [RD_LAT:0] vv_q, vv_d;
    logic [RD_LAT:0] vl_q, vl_d;
    logic [RD_LAT:0] hrd_q, hrd_d;
    logic            host_done_q, host_done_d;
    logic            host_ready_q, host_ready_d;
    logic            clr_busy_q, clr_busy_d;
    logic [10:0]     vid_addr;
    logic            vid_ok, host_ok, clr_go, accept, rd_issue;

    // decode the video cell address and qualify the host/clear handshakes
    always_comb begin
        vid_addr = 11'(vid_row) * 11'(COLS) + 11'(vid_col);
        vid_ok   = (11'(vid_col) < 11'(COLS)) && (11'(vid_row) < 11'(ROWS)) && (vid_addr < 11'(CELLS));
        host_ok  = host_addr < 11'(CELLS);
        clr_go   = clr_start && (state_q == IDLE) && host_ready_q && !clr_busy_q;
        accept   = host_valid && host_ready_q && (state_q == IDLE) && !clr_go;
    end

    // slot arbitration: video always wins, clear beats a pending host access
    always_comb begin
        state_d      = state_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        clr_addr_d   = clr_addr_q;
        clr_data_d   = clr_data_q;
        ram_addr_d   = (vid_req && vid_ok) ? vid_addr : ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        host_done_d  = 1'b0;
        rd_issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_go) begin
                    state_d    = CLEAR;
                    clr_addr_d = 11'd0;
                    clr_data_d = clr_data;
                end else if (accept) begin
                    pend_we_d    = host_we;
                    pend_addr_d  = host_addr;
                    pend_wdata_d = host_wdata;
                    state_d      = host_ok ? HOST_WAIT : IDLE;
                    host_done_d  = !host_ok;
                end
            end
            HOST_WAIT: begin
                if (!vid_req) begin
                    ram_addr_d  = pend_addr_q;
                    ram_we_d    = pend_we_q;
                    ram_wdata_d = pend_we_q ? pend_wdata_q : ram_wdata_q;
                    host_done_d = pend_we_q;
                    rd_issue    = !pend_we_q;
                    state_d     = pend_we_q ? IDLE : HOST_RD;
                end
            end
            HOST_RD: state_d = hrd_q[RD_LAT-1] ? IDLE : HOST_RD;
            CLEAR: begin
                if (!vid_req) begin
                    ram_addr_d  = clr_addr_q;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = clr_data_q;
                    clr_addr_d  = clr_addr_q + 11'd1;
                    state_d     = (clr_addr_q == LAST) ? IDLE : CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
        host_done_d  = host_done_d || hrd_q[RD_LAT-1];
        clr_busy_d   = (state_d == CLEAR) || (state_q == CLEAR);
        host_ready_d = (state_d == IDLE) && !host_done_d && !clr_busy_d;
        vv_d         = {vv_q[RD_LAT-1:0], vid_req};
        vl_d         = {vl_q[RD_LAT-1:0], vid_req && vid_ok};
        hrd_d        = {hrd_q[RD_LAT-1:0], rd_issue};
    end

    // register controller state, RAM port and read-return pipelines
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= 11'd0;
            pend_wdata_q <= 16'd0;
            clr_addr_q   <= 11'd0;
            clr_data_q   <= 16'd0;
            ram_addr_q   <= 11'd0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= 16'd0;
            vv_q         <= '0;
            vl_q         <= '0;
            hrd_q        <= '0;
            host_done_q  <= 1'b0;
            host_ready_q <= 1'b1;
            clr_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            clr_addr_q   <= clr_addr_d;
            clr_data_q   <= clr_data_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            vv_q         <= vv_d;
            vl_q         <= vl_d;
            hrd_q        <= hrd_d;
            host_done_q  <= host_done_d;
            host_ready_q <= host_ready_d;
            clr_busy_q   <= clr_busy_d;
        end
    end

    assign vid_valid            = vv_q[RD_LAT];
    assign {vid_code, vid_attr} = vl_q[RD_LAT] ? ram_rdata : 16'h0000;
    assign host_done            = host_done_q;
    assign host_rdata           = (host_done_q && hrd_q[RD_LAT]) ? ram_rdata : 16'h0000;
    assign host_ready           = host_ready_q;
    assign clr_busy             = clr_busy_q;
    assign ram_addr             = ram_addr_q;
    assign ram_we               = ram_we_q;
    assign ram_wdata            = ram_wdata_q;
endmodule

// File: tb/tb_chrram_arbiter.sv
// tb_chrram_arbiter: directed bench for chrram_arbiter with a 2-cycle-latency RAM model
module tb_chrram_arbiter;
    logic        clk = 1'b0;
    logic        rst, vid_req, vid_valid, host_valid, host_ready, host_we, host_done;
    logic        clr_start, clr_busy, ram_we;
    logic [6:0]  vid_col;
    logic [4:0]  vid_row;
    logic [7:0]  vid_code, vid_attr;
    logic [10:0] host_addr, ram_addr;
    logic [15:0] host_wdata, host_rdata, clr_data, ram_wdata, ram_rdata;
    logic [15:0] mem [0:1999];
    logic [15:0] rd1, rd2;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    chrram_arbiter dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_col(vid_col), .vid_row(vid_row),
        .vid_valid(vid_valid), .vid_code(vid_code), .vid_attr(vid_attr),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_done(host_done), .host_rdata(host_rdata),
        .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 37 + 4352);
    endfunction

    // RAM model: preloaded during reset, two-register read path
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2000; i++) mem[i] <= pat(i);
        end else if (ram_we && ram_addr < 11'd2000) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd1 <= (ram_addr < 11'd2000) ? mem[ram_addr] : 16'hDEAD;
        rd2 <= rd1;
    end
    assign ram_rdata = rd2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic host_xact(input logic we, input logic [10:0] addr, input logic [15:0] wd,
                             output logic [15:0] rd, output int lat);
        host_valid = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        tick();
        host_valid = 1'b0;
        lat = 1;
        while (!host_done && lat < 20) begin
            tick();
            lat++;
        end
        rd = host_rdata;
        if (!host_done) lat = -1;
    endtask

    initial begin
        logic [15:0] rd;
        int lat, nw, bad, rdy, dn, cnt;
        logic prev_last;
        rst = 1'b1; vid_req = 1'b0; vid_col = '0; vid_row = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clr_start = 1'b0; clr_data = '0;
        repeat (3) tick();
        chk("rst_ready", 16'(host_ready), 16'd1);
        chk("rst_vvalid", 16'(vid_valid), 16'd0);
        chk("rst_done", 16'(host_done), 16'd0);
        chk("rst_busy", 16'(clr_busy), 16'd0);
        chk("rst_we", 16'(ram_we), 16'd0);
        chk("rst_addr", 16'(ram_addr), 16'd0);
        rst = 1'b0;
        tick();
        // T1: video fetch of first and last cell
        vid_req = 1'b1; vid_col = 7'd0; vid_row = 5'd0;
        tick();
        chk("t1_addr0", 16'(ram_addr), 16'd0);
        vid_col = 7'd79; vid_row = 5'd24;
        tick();
        chk("t1_addr1999", 16'(ram_addr), 16'd1999);
        chk("t1_no_early_valid", 16'(vid_valid), 16'd0);
        vid_req = 1'b0;
        tick();
        chk("t1_valid_n3", 16'(vid_valid), 16'd1);
        chk("t1_data0", {vid_code, vid_attr}, pat(0));
        tick();
        chk("t1_valid_n4", 16'(vid_valid), 16'd1);
        chk("t1_data1999", {vid_code, vid_attr}, pat(1999));
        tick();
        chk("t1_valid_end", 16'(vid_valid), 16'd0);
        // T2: host write held off by five video cycles
        chk("t2_ready_pre", 16'(host_ready), 16'd1);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd160; host_wdata = 16'h4107;
        vid_req = 1'b1; vid_col = 7'd5; vid_row = 5'd1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            host_valid = 1'b0;
            chk("t2_wait_done", 16'(host_done), 16'd0);
            chk("t2_wait_ready", 16'(host_ready), 16'd0);
        end
        tick();
        vid_req = 1'b0;
        chk("t2_vid_addr", 16'(ram_addr), 16'd85);
        chk("t2_done_early", 16'(host_done), 16'd0);
        tick();
        chk("t2_done", 16'(host_done), 16'd1);
        chk("t2_we", 16'(ram_we), 16'd1);
        chk("t2_addr", 16'(ram_addr), 16'd160);
        chk("t2_wdata", ram_wdata, 16'h4107);
        chk("t2_ready_low", 16'(host_ready), 16'd0);
        tick();
        chk("t2_ready_back", 16'(host_ready), 16'd1);
        chk("t2_done_pulse", 16'(host_done), 16'd0);
        // readback, with a clr_start attempted while not idle
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd160;
        tick();
        host_valid = 1'b0; clr_start = 1'b1; clr_data = 16'h5555;
        tick();
        clr_start = 1'b0;
        chk("t2_clr_ignored", 16'(clr_busy), 16'd0);
        chk("t2_rd_addr", 16'(ram_addr), 16'd160);
        chk("t2_rd_we", 16'(ram_we), 16'd0);
        tick();
        chk("t2_rd_notyet", 16'(host_done), 16'd0);
        tick();
        chk("t2_rd_done", 16'(host_done), 16'd1);
        chk("t2_rd_data", host_rdata, 16'h4107);
        tick();
        chk("t2_rd_ready", 16'(host_ready), 16'd1);
        chk("t2_busy_still0", 16'(clr_busy), 16'd0);
        // T3: out-of-range host and video accesses
        host_xact(1'b0, 11'd2000, 16'h0, rd, lat);
        chk("t3_rd2000_lat", 16'(lat), 16'd1);
        chk("t3_rd2000_data", rd, 16'h0000);
        chk("t3_rd2000_we", 16'(ram_we), 16'd0);
        chk("t3_rd2000_addr", 16'(ram_addr), 16'd160);
        tick();
        chk("t3_ready", 16'(host_ready), 16'd1);
        host_xact(1'b1, 11'd2047, 16'hFFFF, rd, lat);
        chk("t3_wr2047_lat", 16'(lat), 16'd1);
        chk("t3_wr2047_we", 16'(ram_we), 16'd0);
        tick();
        vid_req = 1'b1; vid_col = 7'd80; vid_row = 5'd0;
        tick();
        vid_col = 7'd0; vid_row = 5'd25;
        chk("t3_vid80_hold", 16'(ram_addr), 16'd160);
        tick();
        vid_req = 1'b0;
        tick();
        chk("t3_vid80_valid", 16'(vid_valid), 16'd1);
        chk("t3_vid80_data", {vid_code, vid_attr}, 16'h0000);
        tick();
        chk("t3_row25_valid", 16'(vid_valid), 16'd1);
        chk("t3_row25_data", {vid_code, vid_attr}, 16'h0000);
        tick();
        // T4: full clear with interleaved video; host offer in the start cycle loses
        clr_start = 1'b1; clr_data = 16'h2007;
        host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd7; host_wdata = 16'hBEEF;
        tick();
        clr_start = 1'b0; host_valid = 1'b0;
        chk("t4_busy", 16'(clr_busy), 16'd1);
        chk("t4_ready", 16'(host_ready), 16'd0);
        nw = 0; bad = 0; rdy = 0; dn = 0; prev_last = 1'b0;
        for (int c = 0; c < 4500; c++) begin
            if (!clr_busy) break;
            if (ram_we) begin
                if (ram_addr !== 11'(nw) || ram_wdata !== 16'h2007) bad++;
                nw++;
            end
            if (host_ready) rdy++;
            if (host_done) dn++;
            prev_last = ram_we && ram_addr == 11'd1999;
            vid_req = (c % 2) == 0;
            vid_col = 7'(c % 80);
            vid_row = 5'(c % 25);
            tick();
        end
        vid_req = 1'b0;
        chk("t4_busy_fell", 16'(clr_busy), 16'd0);
        chk("t4_nwrites", 16'(nw), 16'd2000);
        chk("t4_order", 16'(bad), 16'd0);
        chk("t4_ready_low", 16'(rdy), 16'd0);
        chk("t4_no_done", 16'(dn), 16'd0);
        chk("t4_fall_timing", 16'(prev_last), 16'd1);
        chk("t4_ready_back", 16'(host_ready), 16'd1);
        repeat (4) tick();
        host_xact(1'b0, 11'd7, 16'h0, rd, lat);
        chk("t4_rd7_lat", 16'(lat), 16'd4);
        chk("t4_rd7_data", rd, 16'h2007);
        tick();
        vid_req = 1'b1; vid_col = 7'd79; vid_row = 5'd24;
        tick();
        vid_req = 1'b0;
        tick();
        tick();
        chk("t4_vid_valid", 16'(vid_valid), 16'd1);
        chk("t4_vid_data", {vid_code, vid_attr}, 16'h2007);
        tick();
        // T5: reset during an in-flight read and during a clear
        host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd100;
        tick();
        host_valid = 1'b0; vid_req = 1'b1; vid_col = 7'd3; vid_row = 5'd0;
        tick();
        vid_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ready", 16'(host_ready), 16'd1);
        chk("t5_busy", 16'(clr_busy), 16'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (host_done || vid_valid) cnt++;
            tick();
        end
        chk("t5_no_stale", 16'(cnt), 16'd0);
        clr_start = 1'b1; clr_data = 16'h1234;
        tick();
        clr_start = 1'b0;
        repeat (50) tick();
        chk("t5_clr_midway", 16'(clr_busy), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_clr_busy0", 16'(clr_busy), 16'd0);
        chk("t5_clr_ready", 16'(host_ready), 16'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (ram_we || clr_busy) cnt++;
            tick();
        end
        chk("t5_clr_stopped", 16'(cnt), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
